// File: rtl/gray_rx_checker.sv
// Gray-code receiver: synchronizes an incoming Gray bus, decodes it to binary and
// classifies every accepted transition as hold, up-step, down-step or illegal skip.
module gray_rx_checker #(
    parameter int W           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CW          = 8
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [W-1:0]  g,
    input  logic          clr,
    output logic [W-1:0]  bin,
    output logic          up_pulse,
    output logic          down_pulse,
    output logic          err_pulse,
    output logic          fault,
    output logic [CW-1:0] err_cnt,
    output logic [CW-1:0] wrap_cnt,
    output logic          init_done
);

    typedef enum logic {INIT, RUN} state_t;

    localparam int FW = (SYNC_STAGES < 1) ? 1 : $clog2(SYNC_STAGES + 1);

    logic [W-1:0]  s [SYNC_STAGES];
    logic [W-1:0]  gs;
    logic [W-1:0]  d;
    logic [W-1:0]  delta;
    logic [FW-1:0] fill;
    state_t        state;

    assign gs    = s[SYNC_STAGES-1];
    assign delta = d - bin;

    // Binary bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        d = '0;
        for (int unsigned i = 0; i < W; i++)
            d[i] = ^(gs >> i);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++)
                s[i] <= '0;
        end else begin
            s[0] <= g;
            for (int unsigned i = 1; i < SYNC_STAGES; i++)
                s[i] <= s[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= INIT;
            fill       <= '0;
            bin        <= '0;
            up_pulse   <= 1'b0;
            down_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            fault      <= 1'b0;
            err_cnt    <= '0;
            wrap_cnt   <= '0;
            init_done  <= 1'b0;
        end else begin
            up_pulse   <= 1'b0;
            down_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            if (clr) begin
                // bin is deliberately kept; the pending classification is dropped.
                state     <= INIT;
                fill      <= '0;
                fault     <= 1'b0;
                err_cnt   <= '0;
                wrap_cnt  <= '0;
                init_done <= 1'b0;
            end else begin
                case (state)
                    INIT: begin
                        if (fill == FW'(SYNC_STAGES)) begin
                            bin       <= d;
                            state     <= RUN;
                            init_done <= 1'b1;
                        end else begin
                            fill <= fill + 1'b1;
                        end
                    end
                    RUN: begin
                        bin <= d;
                        if (delta == W'(1)) begin
                            up_pulse <= 1'b1;
                            if (bin == '1 && wrap_cnt != '1)
                                wrap_cnt <= wrap_cnt + 1'b1;
                        end else if (delta == '1) begin
                            down_pulse <= 1'b1;
                            if (bin == '0 && wrap_cnt != '1)
                                wrap_cnt <= wrap_cnt + 1'b1;
                        end else if (delta != '0) begin
                            err_pulse <= 1'b1;
                            fault     <= 1'b1;
                            if (err_cnt != '1)
                                err_cnt <= err_cnt + 1'b1;
                        end
                    end
                    default: state <= INIT;
                endcase
            end
        end
    end

endmodule
